// File: rtl/car_request_unit_if.sv
// car_request_unit_if: sensor/grant inputs and demand outputs of car_request_unit.
// master = controller/stimulus side, slave = car_request_unit.
interface car_request_unit_if #(
  parameter int CNT_BITS = 4
) ();
  logic [1:0]          sensor_raw;
  logic [1:0]          grant;
  logic [1:0]          req;
  logic [1:0]          arrival;
  logic [CNT_BITS-1:0] count0;
  logic [CNT_BITS-1:0] count1;
  logic [1:0]          ovf;

  modport master (output sensor_raw, grant,
                  input  req, arrival, count0, count1, ovf);
  modport slave  (input  sensor_raw, grant,
                  output req, arrival, count0, count1, ovf);
endinterface

// File: rtl/car_request_unit.sv
// car_request_unit: per-road sensor debounce, pending-car counting and level
// request generation feeding the traffic-light controller.
// Build macro: SENSOR_SYNC_EN inserts a 2-flop synchronizer on sensor_raw
// (+2 cycles sensor-to-arrival latency); undefined feeds sensor_raw directly.

// One road: debouncer, arrival pulse, saturating pending-car counter.
module car_request_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_BITS        = 4
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                s,
  input  logic                gnt,
  output logic                req,
  output logic                arrival,
  output logic [CNT_BITS-1:0] count,
  output logic                ovf
);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic                db, db_nxt;
  logic [DB_W-1:0]     dbc, dbc_nxt;
  logic                rise, dep, sat;
  logic [CNT_BITS-1:0] cnt_nxt;

  // Next debounced level, arrival detect and counter update.
  always_comb begin
    db_nxt  = db;
    dbc_nxt = '0;
    rise    = 1'b0;
    if (s != db) begin
      if (dbc == DB_LAST) begin
        db_nxt = s;
        rise   = s;          // only 0->1 is a car
      end else begin
        dbc_nxt = dbc + 1'b1;
      end
    end
    dep     = gnt && (count != '0);
    sat     = 1'b0;
    cnt_nxt = count;
    if (rise && !dep) begin
      if (count == CNT_MAX) sat = 1'b1;
      else                  cnt_nxt = count + 1'b1;
    end else if (dep && !rise) begin
      cnt_nxt = count - 1'b1;
    end
  end

  // State and registered outputs; req tracks the new count so it is a flop too.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      db      <= 1'b0;
      dbc     <= '0;
      arrival <= 1'b0;
      count   <= '0;
      req     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      db      <= db_nxt;
      dbc     <= dbc_nxt;
      arrival <= rise;
      count   <= cnt_nxt;
      req     <= (cnt_nxt != '0);
      ovf     <= ovf | sat;
    end
  end
endmodule

module car_request_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_BITS        = 4
) (
  input logic               clk_2,
  input logic               reset,
  car_request_unit_if.slave bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]               s_samp, gnt_ok, req, arrival, ovf;
  logic [NUM_LANES-1:0][CNT_BITS-1:0] count;

`ifdef SENSOR_SYNC_EN
  logic [NUM_LANES-1:0] sync_q1, sync_q2;

  // Two-flop synchronizer between the raw switches and the debouncers.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.sensor_raw;
      sync_q2 <= sync_q1;
    end
  end
  assign s_samp = sync_q2;
`else
  assign s_samp = bus.sensor_raw;
`endif

  // Both roads green is illegal; treat it as all red so nobody departs.
  assign gnt_ok = (bus.grant == 2'b11) ? '0 : bus.grant;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    car_request_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_BITS       (CNT_BITS)
    ) u_lane (
      .clk_2  (clk_2),
      .reset  (reset),
      .s      (s_samp[i]),
      .gnt    (gnt_ok[i]),
      .req    (req[i]),
      .arrival(arrival[i]),
      .count  (count[i]),
      .ovf    (ovf[i])
    );
  end

  assign bus.req     = req;
  assign bus.arrival = arrival;
  assign bus.ovf     = ovf;
  assign bus.count0  = count[0];
  assign bus.count1  = count[1];
endmodule

// File: tb/tb_car_request_unit.sv
// tb_car_request_unit: directed scenarios plus randomized traffic, every cycle
// checked against a queue/arithmetic reference model. Honours SENSOR_SYNC_EN.
module tb_car_request_unit;
  localparam int D    = 4;
  localparam int CB   = 4;
  localparam int CMAX = (1 << CB) - 1;
  localparam int VW   = 6 + 2 * CB;
`ifdef SENSOR_SYNC_EN
  localparam int LAT = D + 1;
`else
  localparam int LAT = D - 1;
`endif

  logic clk_2 = 1'b0;
  logic reset;

  car_request_unit_if #(.CNT_BITS(CB)) bus ();

  car_request_unit #(.DEBOUNCE_CYCLES(D), .CNT_BITS(CB)) dut (
    .clk_2(clk_2),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk_2 = ~clk_2;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state
  int m_cnt [2];
  bit m_db  [2];
  bit m_arr [2];
  bit m_ovf [2];
  bit hist  [2][$];   // samples differing from db since it last settled
`ifdef SENSOR_SYNC_EN
  bit [1:0] m_d1, m_d2;
`endif

  int n_arr, arr_at, seen1, len;

  task automatic model_step(input bit rst, input bit [1:0] sens, input bit [1:0] gnt);
    bit [1:0] s, g;
    bit rise, dep;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_db[i] = 0; m_arr[i] = 0; m_ovf[i] = 0;
        hist[i].delete();
      end
`ifdef SENSOR_SYNC_EN
      m_d1 = 0; m_d2 = 0;
`endif
      return;
    end
`ifdef SENSOR_SYNC_EN
    s = m_d2; m_d2 = m_d1; m_d1 = sens;
`else
    s = sens;
`endif
    g = (gnt == 2'b11) ? 2'b00 : gnt;
    for (int i = 0; i < 2; i++) begin
      rise = 0;
      if (s[i] == m_db[i]) hist[i].delete();
      else begin
        hist[i].push_back(s[i]);
        if (hist[i].size() == D) begin
          m_db[i] = s[i];
          rise    = s[i];
          hist[i].delete();
        end
      end
      dep = g[i] && (m_cnt[i] > 0);
      m_cnt[i] = m_cnt[i] + (rise ? 1 : 0) - (dep ? 1 : 0);
      if (m_cnt[i] > CMAX) begin
        m_cnt[i] = CMAX;
        m_ovf[i] = 1;
      end
      m_arr[i] = rise;
    end
  endtask

  function automatic logic [VW-1:0] m_vec();
    logic [1:0] r, a, o;
    for (int i = 0; i < 2; i++) begin
      r[i] = (m_cnt[i] != 0);
      a[i] = m_arr[i];
      o[i] = m_ovf[i];
    end
    return {r, a, o, CB'(m_cnt[1]), CB'(m_cnt[0])};
  endfunction

  function automatic logic [VW-1:0] d_vec();
    return {bus.req, bus.arrival, bus.ovf, bus.count1, bus.count0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    model_step(reset, bus.sensor_raw, bus.grant);
    #1;
    chk("cycle", 32'(d_vec()), 32'(m_vec()));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One debounced car on each selected road, then settle low again.
  task automatic car(input bit [1:0] roads);
    bus.sensor_raw = roads;
    ticks(D + 3);
    bus.sensor_raw = 2'b00;
    ticks(D + 3);
  endtask

  initial begin
    reset = 1'b1;
    bus.sensor_raw = 2'b00;
    bus.grant = 2'b00;
    ticks(2);
    chk("reset_outs", 32'(d_vec()), 32'd0);
    reset = 1'b0;

    // Clean arrival on road 0
    bus.sensor_raw = 2'b01;
    n_arr = 0; arr_at = -1; seen1 = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.arrival[0]) begin
        n_arr++;
        if (arr_at < 0) arr_at = k;
      end
      if (bus.arrival[1] || bus.req[1]) seen1 = 1;
    end
    chk("arr_edge", arr_at, LAT);
    chk("arr_pulses", n_arr, 1);
    chk("clean_count0", 32'(bus.count0), 32'd1);
    chk("clean_req", 32'(bus.req), 32'b01);
    chk("road1_idle", seen1 + 32'(bus.count1), 32'd0);
    bus.sensor_raw = 2'b00;
    ticks(D + 3);

    // Glitch rejection on road 1: 3 high, 1 low, 3 high
    seen1 = 0;
    for (int k = 0; k < 7; k++) begin
      bus.sensor_raw = (k != 3) ? 2'b10 : 2'b00;
      tick();
      if (bus.arrival[1]) seen1 = 1;
    end
    bus.sensor_raw = 2'b00;
    for (int k = 0; k < D + 3; k++) begin
      tick();
      if (bus.arrival[1]) seen1 = 1;
    end
    chk("glitch_arrival", seen1, 0);
    chk("glitch_count1", 32'(bus.count1), 32'd0);

    // Service: count0=3 then drain with grant held
    reset = 1'b1; tick(); reset = 1'b0;
    car(2'b01); car(2'b01); car(2'b01);
    chk("svc_count3", 32'(bus.count0), 32'd3);
    bus.grant = 2'b01;
    tick(); chk("svc_count2", 32'(bus.count0), 32'd2);
    tick(); chk("svc_count1", 32'(bus.count0), 32'd1);
    chk("svc_req_hi", 32'(bus.req[0]), 32'd1);
    tick(); chk("svc_count0", 32'(bus.count0), 32'd0);
    chk("svc_req_lo", 32'(bus.req[0]), 32'd0);
    tick(); chk("svc_nowrap", 32'(bus.count0), 32'd0);
    bus.grant = 2'b00;

    // Arrival landing on a grant edge
    car(2'b01);
    bus.sensor_raw = 2'b01;
    ticks(LAT);
    bus.grant = 2'b01;
    tick();
    chk("simul_arrival", 32'(bus.arrival[0]), 32'd1);
    chk("simul_count", 32'(bus.count0), 32'd1);
    bus.grant = 2'b00;
    ticks(3);
    bus.sensor_raw = 2'b00;
    ticks(D + 3);

    // Saturation on road 0
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 15; c++) car(2'b01);
    chk("sat_15_count", 32'(bus.count0), 32'd15);
    chk("sat_15_noovf", 32'(bus.ovf), 32'd0);
    car(2'b01);
    chk("sat_16_count", 32'(bus.count0), 32'd15);
    chk("sat_16_ovf", 32'(bus.ovf), 32'b01);
    bus.grant = 2'b01;
    tick();
    bus.grant = 2'b00;
    chk("sat_drain_count", 32'(bus.count0), 32'd14);
    chk("sat_drain_ovf", 32'(bus.ovf[0]), 32'd1);

    // Illegal grant 2'b11
    reset = 1'b1; tick(); reset = 1'b0;
    car(2'b11); car(2'b11);
    chk("ill_pre", 32'({bus.count1, bus.count0}), 32'({CB'(2), CB'(2)}));
    bus.grant = 2'b11;
    ticks(3);
    bus.grant = 2'b00;
    chk("ill_post", 32'({bus.count1, bus.count0}), 32'({CB'(2), CB'(2)}));

    // Mid-debounce reset, then fresh samples required
    bus.sensor_raw = 2'b01;
    ticks(2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_outs", 32'(d_vec()), 32'd0);
    ticks(LAT);
    chk("fresh_reject", 32'(bus.count0), 32'd0);
    tick();
    chk("fresh_accept", 32'(bus.count0), 32'd1);
    bus.sensor_raw = 2'b00;
    ticks(D + 3);

    // Randomized traffic
    for (int seg = 0; seg < 120; seg++) begin
      bus.sensor_raw = 2'($urandom);
      len = $urandom_range(1, 2 * D);
      for (int k = 0; k < len; k++) begin
        bus.grant = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        reset = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/car_request_unit.md
# car_request_unit

Input-conditioning stage that sits directly upstream of the traffic-light controller. It takes the two raw car-sensor switches, one per road, and debounces them. It counts arrivals into per-road pending-car counters and presents a level request per road to the controller. Cars are retired from a road's counter while the controller grants that road green, so the controller sees a clean, stateful demand signal instead of raw switch levels.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive differing samples required to flip a debounced level; legal range is 1 or more.
- CNT_BITS, default 4: width of each pending-car counter.

Ports:
- clk_2 (input, 1): sole clock; all state updates on its rising edge.
- reset (input, 1): synchronous, active-high reset.
- sensor_raw (input, 2): raw car sensors; bit 0 is road 0 and bit 1 is road 1.
- grant (input, 2): road currently green, one-hot; 2'b00 means all red.
- req (output, 2): req[i] is 1 when count_i is not 0.
- arrival (output, 2): one-cycle pulse when a road's debounced sensor rises.
- count0, count1 (output, CNT_BITS each): pending cars for road 0 and road 1.
- ovf (output, 2): sticky flag, set when an arrival is lost to saturation.

## Operation
- Reset: all state is cleared on a clk_2 edge with reset=1. This includes any debounce already in progress. Output values:
  - req=0, arrival=0, count0=count1=0, ovf=0.
  - Debounced levels are 0; debounce counters are 0; synchronizer flops are 0.
- Debounce, per road, independently. Let s be the sampled input and db the debounced level.
  - When s != db and the debounce counter equals DEBOUNCE_CYCLES-1: db<=s and the counter is set to 0.
  - When s != db otherwise: the counter increments.
  - When s == db: the counter is set to 0. Any glitch shorter than DEBOUNCE_CYCLES therefore restarts the count.
- Arrival: on the edge where db goes 0->1, arrival[i]<=1. On every other edge, arrival[i]<=0.
  - A falling db (1->0) produces no event.
- Departure: dep_i = grant[i] and count_i != 0, one car per cycle.
  - grant==2'b11 is illegal and is treated as 2'b00, so neither road departs.
- Counter update, per road, on each edge:
  - Arrival and departure together: count is unchanged.
  - Arrival only, count below max: count+1.
  - Arrival only, count at max (2^CNT_BITS-1): count stays at max and ovf[i]<=1.
  - Departure only: count-1.
  - Neither: count is unchanged.
- Width rule: counts are unsigned. They never wrap in either direction; grant on a road whose count is 0 leaves it at 0.
- ovf is cleared only by reset.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Without the synchronizer, sensor_raw is sampled directly. A rise held stable from edge k is seen at edges k..k+DEBOUNCE_CYCLES-1.
  - db flips at edge k+DEBOUNCE_CYCLES-1.
  - On that same edge, arrival goes high and count increments.
  - req is high after that edge.
- grant to count decrement takes 1 edge. req falls on the edge where count reaches 0.
- A sensor must stay low for DEBOUNCE_CYCLES samples and then high for DEBOUNCE_CYCLES samples to register a second car.

## Configuration
- SENSOR_SYNC_EN defined: a 2-flop synchronizer sits between sensor_raw and the debouncer. This adds exactly 2 cycles of sensor-to-arrival latency. The synchronizer flops reset to 0.
- SENSOR_SYNC_EN undefined: sensor_raw feeds the debouncer directly, with the latency given under Timing. Counter and grant behaviour are identical in both builds.

## Test plan
The defaults apply (DEBOUNCE_CYCLES=4, CNT_BITS=4) and SENSOR_SYNC_EN is undefined, except where a scenario says otherwise.
- Clean arrival: after reset, sensor_raw=2'b01 held high for 6 cycles.
  - arrival[0] is high for exactly one cycle, 3 edges after the first high sample.
  - count0=1 and req=2'b01.
  - Road 1 stays idle.
- Glitch rejection: sensor_raw[1] pulses high for 3 cycles, low for 1, then high for 3.
  - No arrival occurs and count1 stays 0.
- Service and simultaneity:
  - With count0=3 and grant=2'b01 held, count0 goes 2, 1, 0 on successive edges and req[0] falls with the last decrement.
  - An arrival landing on a grant edge leaves count0 unchanged.
- Saturation: 16 debounced arrivals on road 0 with grant=0.
  - count0 saturates at 15 and ovf[0]=1.
  - One granted cycle then gives count0=14 with ovf[0] still 1.
- Illegal grant and mid-run reset:
  - grant=2'b11 with count0=2 and count1=2 leaves both counts unchanged.
  - Asserting reset for 1 cycle mid-debounce clears every output to 0. A subsequent high is then rejected unless it is held for 4 fresh samples.
- SENSOR_SYNC_EN build: repeating the clean-arrival scenario gives an arrival 2 cycles later than in the unsynchronized build.
